key_matrix_scan: RTL and testbench

Parametrised ROWS x COLS matrix keypad scanner for the clock front panel.
- Synchronises row inputs and debounces both press and release.
- Scans columns with a settle delay, encodes a single pressed key to a linear code and flags multi-key presses.
- Feeds the time-set / mode controller with one-cycle key events.

---
 rtl/key_matrix_scan.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_key_matrix_scan.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scan.sv
// ---------------------------------------------------------------------------
// key_matrix_scan
//
// Purpose:
//   ROWS x COLS matrix keypad scanner for the clock front panel. Row lines are
//   synchronised, a press is debounced with all columns driven low, then the
//   columns are scanned one at a time to locate the key. A single hit produces
//   a one-cycle key event with a linear code. Zero or multiple hits produce a
//   one-cycle multi-key pulse. Release is debounced before a new press is
//   accepted.
//
// Optional feature (compile-time macro KEY_MATRIX_REPEAT_EN):
//   When defined, a held key re-issues Key_flag together with Key_repeat after
//   REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles. When undefined,
//   Key_repeat is tied low and no hold counter exists.
//
// Ports:
//   Clk              in   system clock
//   Rst_n            in   asynchronous active-low reset
//   Key_Board_Row_i  in   [ROWS-1:0] row lines, pulled up, low = key closed
//   Key_Board_Col_o  out  [COLS-1:0] column drive, low = column selected
//   Key_flag         out  one-cycle pulse, new valid key event
//   Key_Value        out  [CODE_W-1:0] code of last valid key (row*COLS+col)
//   Key_multi        out  one-cycle pulse, scan found 0 or >1 keys
//   Key_held         out  high from a valid event until release is filtered
//   Key_release      out  one-cycle pulse when a held key's release completes
//   Key_repeat       out  high together with Key_flag on an auto-repeat event
//
// Output protocol: Key_flag, Key_multi, Key_release and Key_repeat are
// registered single-cycle strobes with no back-pressure; the consumer must
// sample them every cycle. Key_Value is valid whenever Key_flag is high and
// stays stable until the next valid event.
//
// The FSM register is named `state` so checkers can bind to it directly.
// ---------------------------------------------------------------------------
module key_matrix_scan #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SETTLE_CYCLES   = 4,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ROWS-1:0]   Key_Board_Row_i,
    output logic [COLS-1:0]   Key_Board_Col_o,
    output logic              Key_flag,
    output logic [CODE_W-1:0] Key_Value,
    output logic              Key_multi,
    output logic              Key_held,
    output logic              Key_release,
    output logic              Key_repeat
);

    // One counter width serves debounce and repeat timing so neither can wrap.
    localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    // A column change reaches rows_s two cycles later through the
    // synchroniser, so the wait per column is never shorter than that.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 2) ? 2 : SETTLE_CYCLES;
    localparam int ST_W       = $clog2(SETTLE_EFF + 1);
    localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_EFF);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(COLS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRESS   = 3'd1;
    localparam logic [2:0] S_SCAN    = 3'd2;
    localparam logic [2:0] S_RESULT  = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]        state;
    logic [ROWS-1:0]   sync1;
    logic [ROWS-1:0]   rows_s;
    logic [CNT_W-1:0]  cnt;
    logic [ST_W-1:0]   settle;
    logic [COL_W-1:0]  col_idx;
    logic [COLS-1:0]   col_q;
    logic [1:0]        hit_cnt;      // saturates at 2: only "exactly one" matters
    logic [ROW_W-1:0]  first_row;
    logic [COL_W-1:0]  first_col;
    logic              key_flag_q;
    logic              key_multi_q;
    logic              key_held_q;
    logic              key_release_q;
    logic [CODE_W-1:0] key_value_q;

    logic              rows_all_high;
    logic [1:0]        col_hits;
    logic [ROW_W-1:0]  col_first_row;
    logic [2:0]        hit_sum;
    logic [1:0]        hit_next;
    logic [CODE_W-1:0] code_next;

    assign rows_all_high = &rows_s;

    // Hits in the currently selected column; descending loop leaves the
    // lowest-numbered low row in col_first_row.
    always_comb begin
        col_hits      = 2'd0;
        col_first_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!rows_s[r]) begin
                col_first_row = ROW_W'(r);
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
            end
        end
    end

    always_comb begin
        hit_sum   = {1'b0, hit_cnt} + {1'b0, col_hits};
        hit_next  = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
        code_next = CODE_W'(int'(first_row) * COLS + int'(first_col));
    end

`ifdef KEY_MATRIX_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             rep_phase;     // 0: waiting for first repeat, 1: periodic
    logic             key_repeat_q;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= S_IDLE;
            sync1         <= '1;
            rows_s        <= '1;
            cnt           <= '0;
            settle        <= '0;
            col_idx       <= '0;
            col_q         <= '0;
            hit_cnt       <= 2'd0;
            first_row     <= '0;
            first_col     <= '0;
            key_flag_q    <= 1'b0;
            key_multi_q   <= 1'b0;
            key_held_q    <= 1'b0;
            key_release_q <= 1'b0;
            key_value_q   <= '0;
`ifdef KEY_MATRIX_REPEAT_EN
            hold_cnt      <= '0;
            rep_phase     <= 1'b0;
            key_repeat_q  <= 1'b0;
`endif
        end else begin
            sync1         <= Key_Board_Row_i;
            rows_s        <= sync1;
            key_flag_q    <= 1'b0;
            key_multi_q   <= 1'b0;
            key_release_q <= 1'b0;
`ifdef KEY_MATRIX_REPEAT_EN
            key_repeat_q  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    col_q <= '0;
                    if (!rows_all_high) begin
                        state <= S_PRESS;
                        cnt   <= '0;
                    end
                end

                S_PRESS: begin
                    if (rows_all_high) begin
                        state <= S_IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state     <= S_SCAN;
                        col_idx   <= '0;
                        settle    <= '0;
                        hit_cnt   <= 2'd0;
                        first_row <= '0;
                        first_col <= '0;
                        col_q     <= ~COLS'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_SCAN: begin
                    if (settle == SETTLE_LAST) begin
                        settle  <= '0;
                        hit_cnt <= hit_next;
                        if (hit_cnt == 2'd0 && col_hits != 2'd0) begin
                            first_row <= col_first_row;
                            first_col <= col_idx;
                        end
                        if (col_idx == COL_LAST) begin
                            state <= S_RESULT;
                            col_q <= '0;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                            col_q   <= ~(COLS'(1) << (col_idx + 1'b1));
                        end
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end

                S_RESULT: begin
                    if (hit_cnt == 2'd1) begin
                        key_flag_q  <= 1'b1;
                        key_value_q <= code_next;
                        key_held_q  <= 1'b1;
                    end else begin
                        key_multi_q <= 1'b1;
                    end
                    state <= S_WAIT;
`ifdef KEY_MATRIX_REPEAT_EN
                    hold_cnt  <= '0;
                    rep_phase <= 1'b0;
`endif
                end

                S_WAIT: begin
                    if (rows_all_high) begin
                        state <= S_RELEASE;
                        cnt   <= '0;
`ifdef KEY_MATRIX_REPEAT_EN
                        hold_cnt  <= '0;
                        rep_phase <= 1'b0;
                    end else if (key_held_q) begin
                        if ((!rep_phase && hold_cnt == DELAY_LAST) ||
                            (rep_phase && hold_cnt == PERIOD_LAST)) begin
                            key_flag_q   <= 1'b1;
                            key_repeat_q <= 1'b1;
                            hold_cnt     <= '0;
                            rep_phase    <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
`endif
                    end
                end

                S_RELEASE: begin
                    if (!rows_all_high) begin
                        cnt <= '0;
`ifdef KEY_MATRIX_REPEAT_EN
                        // Key came back: resume holding, repeat delay restarts.
                        state     <= S_WAIT;
                        hold_cnt  <= '0;
                        rep_phase <= 1'b0;
`endif
                    end else if (cnt == DEB_LAST) begin
                        state <= S_IDLE;
                        if (key_held_q) begin
                            key_release_q <= 1'b1;
                            key_held_q    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    col_q <= '0;
                end
            endcase
        end
    end

    assign Key_Board_Col_o = col_q;
    assign Key_flag        = key_flag_q;
    assign Key_Value       = key_value_q;
    assign Key_multi       = key_multi_q;
    assign Key_held        = key_held_q;
    assign Key_release     = key_release_q;
`ifdef KEY_MATRIX_REPEAT_EN
    assign Key_repeat      = key_repeat_q;
`else
    assign Key_repeat      = 1'b0;
`endif

endmodule

// File: tb/tb_key_matrix_scan.sv
// ---------------------------------------------------------------------------
// tb_key_matrix_scan
//
// Bench for key_matrix_scan with ROWS=4, COLS=4, DEBOUNCE_CYCLES=16,
// SETTLE_CYCLES=2, CODE_W=4, REPEAT_DELAY=40, REPEAT_PERIOD=10.
// A behavioural keypad model pulls a row low when a pressed key sits on a
// column driven low. Directed stimulus pushes expected events into exp_q;
// a monitor on the falling edge pops and compares every output strobe.
// Event word: {repeat, flag, multi, release, Key_Value, Key_held}.
// ---------------------------------------------------------------------------
module tb_key_matrix_scan;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int CODE_W  = 4;
    localparam int DEB     = 16;
    localparam int SETTLE  = 2;
    localparam int RDELAY  = 40;
    localparam int RPERIOD = 10;
    localparam int EW      = 9;

    localparam logic [3:0] K_FLAG    = 4'b0100;
    localparam logic [3:0] K_REPEAT  = 4'b1100;
    localparam logic [3:0] K_MULTI   = 4'b0010;
    localparam logic [3:0] K_RELEASE = 4'b0001;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic [ROWS-1:0]   row_i;
    logic [COLS-1:0]   col_o;
    logic              Key_flag;
    logic [CODE_W-1:0] Key_Value;
    logic              Key_multi;
    logic              Key_held;
    logic              Key_release;
    logic              Key_repeat;

    logic [15:0]       keys = 16'h0000;
    logic [ROWS-1:0]   glitch = '0;

    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     mon_obs;
    logic [EW-1:0]     mon_exp;
    int                n_checks = 0;
    int                n_pass = 0;
    int                cyc = 0;
    int                rise_cyc = 0;
    bit                rel_lat_en = 1'b0;

    // ---------------- clock / reset / keypad model ----------------
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always_comb begin
        row_i = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keys[r*COLS+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
        row_i = row_i & ~glitch;
    end

    key_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W),
        .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SETTLE),
        .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Key_Board_Row_i(row_i),
        .Key_Board_Col_o(col_o),
        .Key_flag(Key_flag),
        .Key_Value(Key_Value),
        .Key_multi(Key_multi),
        .Key_held(Key_held),
        .Key_release(Key_release),
        .Key_repeat(Key_repeat)
    );

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] ev(input logic [3:0] kind, input logic [3:0] val,
                                         input logic held);
        return {kind, val, held};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge Clk) begin
        if (Key_flag || Key_multi || Key_release || Key_repeat) begin
            mon_obs = {Key_repeat, Key_flag, Key_multi, Key_release, Key_Value, Key_held};
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event got=%h expected=none", mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", mon_obs, mon_exp);
            end
            if (Key_release && rel_lat_en) begin
                n_checks++;
                if ((cyc - rise_cyc) >= 17 && (cyc - rise_cyc) <= 20) n_pass++;
                else $display("FAIL release_latency got=%0d expected=17..20", cyc - rise_cyc);
                rel_lat_en = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_event(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (Key_flag || Key_multi) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout got=none expected=event within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_release(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (Key_release) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout got=none expected=release within %0d cycles", name, budget);
        end
    endtask

    task automatic release_keys(input logic [3:0] val);
        exp_q.push_back(ev(K_RELEASE, val, 1'b0));
        keys       = 16'h0000;
        rise_cyc   = cyc;
        rel_lat_en = 1'b1;
    endtask

`ifdef KEY_MATRIX_REPEAT_EN
    // Repeats fall at flag+RDELAY+k*RPERIOD while the held rows still read
    // low; they stop two cycles after the release is driven (synchroniser).
    task automatic push_repeats(input logic [3:0] val, input int hold);
        for (int t = RDELAY; t <= hold + 2; t += RPERIOD)
            exp_q.push_back(ev(K_REPEAT, val, 1'b1));
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        int col_bad;
        bit found;

        // Reset state
        tick(3);
        check("reset_col", col_o, 4'b0000);
        check("reset_strobes", {Key_flag, Key_multi, Key_held, Key_release, Key_repeat}, 5'b0);
        check("reset_value", Key_Value, 4'd0);
        Rst_n = 1'b1;
        tick(5);
        check("idle_col", col_o, 4'b0000);

        // 1: row2/col1 -> code 9, hold 195 cycles past the flag
        exp_q.push_back(ev(K_FLAG, 4'd9, 1'b1));
        keys = 16'h0200;
        wait_event("key9", 100);
`ifdef KEY_MATRIX_REPEAT_EN
        push_repeats(4'd9, 195);
`endif
        tick(20);
        check("key9_held", Key_held, 1'b1);
        tick(175);
        release_keys(4'd9);
        wait_release("key9_release", 60);
        check("key9_held_cleared", Key_held, 1'b0);
        tick(5);

        // 2: 5-cycle glitch on row0 in IDLE is rejected
        col_bad = 0;
        glitch  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (col_o != 4'b0000) col_bad++;
        end
        glitch = '0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (col_o != 4'b0000) col_bad++;
        end
        check("glitch_col_driven", col_bad, 0);
        check("glitch_state_idle", dut.state, 3'd0);

        // 3: row1/col0 + row1/col3 -> multi, value keeps 9, not held
        exp_q.push_back(ev(K_MULTI, 4'd9, 1'b0));
        keys = 16'h0090;
        wait_event("multi", 100);
        check("multi_held", Key_held, 1'b0);
        tick(10);
        keys = 16'h0000;
        tick(40);
        check("multi_state_idle", dut.state, 3'd0);

        // 4: row0/col2 -> code 2, then release bounce
        exp_q.push_back(ev(K_FLAG, 4'd2, 1'b1));
        keys = 16'h0004;
        wait_event("key2", 100);
        tick(30);
        for (int i = 0; i < 3; i++) begin
            keys = 16'h0000;
            tick(8);
            keys = 16'h0004;
            tick(8);
        end
        release_keys(4'd2);
        wait_release("key2_release", 60);
        tick(5);

        // 5: reset asserted while column 2 is being scanned
        keys  = 16'h4000;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(1);
            if (col_o == 4'b1011) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL scan_col2_timeout got=%b expected=1011", col_o);
        end
        Rst_n = 1'b0;
        #1;
        check("midscan_reset_col", col_o, 4'b0000);
        check("midscan_reset_strobes",
              {Key_flag, Key_multi, Key_held, Key_release, Key_repeat}, 5'b0);
        check("midscan_reset_value", Key_Value, 4'd0);
        keys = 16'h0000;
        tick(3);
        Rst_n = 1'b1;
        tick(60);
        check("post_reset_state_idle", dut.state, 3'd0);

        // 6: row3/col3 -> code 15, hold 75 cycles past the flag
        exp_q.push_back(ev(K_FLAG, 4'd15, 1'b1));
        keys = 16'h8000;
        wait_event("key15", 100);
`ifdef KEY_MATRIX_REPEAT_EN
        push_repeats(4'd15, 75);
`endif
        tick(75);
        release_keys(4'd15);
        wait_release("key15_release", 60);
        tick(10);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
